vend_payment_unit: RTL and testbench

- Payment datapath of the vending machine, driven by the external 2-bit vend state machine.
- Accumulates coin cash or checks a card credit balance against the selected item's cost.
- Runs the inventory-reduce and state-advance handshakes, computes refunds or change, and converts change into quarter/dime/nickel counts.
- Also contains the latch-based clock gate used for the selection register.

---
 rtl/vend_payment_unit_pkg.sv | 28 ++
 rtl/vend_payment_unit_change_dispenser.sv | 31 +++
 rtl/vend_payment_unit_clock_gate_latch.sv | 16 +
 rtl/vend_payment_unit.sv | 176 +++++++++++++++++
 tb/tb_vend_payment_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_payment_unit_pkg.sv
// Shared constants and state types for the vending-machine payment datapath.
package vend_payment_unit_pkg;

    localparam int unsigned VEND_NUM_ITEMS = 8;
    localparam int unsigned VEND_BAL_W     = 9;

    localparam int unsigned COIN_NICKEL  = 5;
    localparam int unsigned COIN_DIME    = 10;
    localparam int unsigned COIN_QUARTER = 25;
    localparam int unsigned COIN_DOLLAR  = 100;

    // Encoding driven by the external vend state machine.
    typedef enum logic [1:0] {
        SELECT = 2'b00,
        PAY    = 2'b01,
        VEND   = 2'b10,
        CANCEL = 2'b11
    } vend_state_e;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        REDUCE,
        FINISH,
        REFUND
    } pay_state_e;

endpackage

// File: rtl/vend_payment_unit_change_dispenser.sv
// Greedy conversion of a change amount into quarter/dime/nickel counts.
module vend_payment_unit_change_dispenser
    import vend_payment_unit_pkg::*;
#(
    parameter int unsigned BAL_W = VEND_BAL_W
) (
    input  logic [BAL_W-1:0] change,
    output logic [4:0]       quarter_o,
    output logic [4:0]       dime_o,
    output logic [4:0]       nickel_o
);

    logic [BAL_W-1:0] quarters;
    logic [BAL_W-1:0] rem_quarter;
    logic [BAL_W-1:0] dimes;
    logic [BAL_W-1:0] rem_dime;
    logic [BAL_W-1:0] nickels;

    // Sub-nickel remainder is simply dropped.
    always_comb begin
        quarters    = change / BAL_W'(COIN_QUARTER);
        rem_quarter = change % BAL_W'(COIN_QUARTER);
        dimes       = rem_quarter / BAL_W'(COIN_DIME);
        rem_dime    = rem_quarter % BAL_W'(COIN_DIME);
        nickels     = rem_dime / BAL_W'(COIN_NICKEL);
        quarter_o   = quarters[4:0];
        dime_o      = dimes[4:0];
        nickel_o    = nickels[4:0];
    end

endmodule

// File: rtl/vend_payment_unit_clock_gate_latch.sv
// Latch-based clock gate: enable is captured while clk is low so gclk never glitches.
module vend_payment_unit_clock_gate_latch (
    input  logic clk,
    input  logic clk_en,
    output logic gclk
);

    logic en_l;

    always_latch begin
        if (!clk) en_l <= clk_en;
    end

    assign gclk = clk & en_l;

endmodule

// File: rtl/vend_payment_unit.sv
// Payment datapath: coin accumulation, card charge, inventory/state handshakes and refunds.
module vend_payment_unit
    import vend_payment_unit_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = VEND_NUM_ITEMS,
    parameter int unsigned BAL_W     = VEND_BAL_W
) (
    input  logic                   clk2,
    input  logic                   rst,
    input  logic                   clk_en,
    output logic                   gclk,
    input  logic [1:0]             state,
    input  logic                   cancelled,
    input  logic                   payment_method,
    input  logic [8*NUM_ITEMS-1:0] store_cost,
    input  logic [3:0]             cur_index,
    input  logic [BAL_W-1:0]       cred_balance,
    input  logic                   dollar,
    input  logic                   quarter,
    input  logic                   dime,
    input  logic                   nickel,
    input  logic                   full_inventory,
    input  logic                   reduce_inventory_done,
    input  logic                   change_state_done,
    output logic                   reduce_inventory,
    output logic                   change_state,
    output logic                   cancelled_done,
    output logic [BAL_W-1:0]       balance,
    output logic [BAL_W-1:0]       new_credit,
    output logic [BAL_W-1:0]       change,
    output logic [4:0]             quarter_o,
    output logic [4:0]             dime_o,
    output logic [4:0]             nickel_o
);

    pay_state_e fsm, fsm_next;

    logic [3:0]       coins;
    logic [3:0]       coin_prev;
    logic [3:0]       rise;
    logic [BAL_W:0]   coin_sum;
    logic [BAL_W:0]   coin_total;

    logic [7:0]       cost;
    logic             cost_valid;
    logic [BAL_W-1:0] cost_ext;
    logic             funds_ok;
    logic             start_ok;
    logic             cancel_req;

    logic [BAL_W-1:0] balance_next, change_next, new_credit_next;
    logic             reduce_next, cstate_next, cdone_next;

    assign coins = {dollar, quarter, dime, nickel};
    assign rise  = coins & ~coin_prev;

    always_comb begin
        coin_sum = '0;
        if (rise[3]) coin_sum = coin_sum + (BAL_W+1)'(COIN_DOLLAR);
        if (rise[2]) coin_sum = coin_sum + (BAL_W+1)'(COIN_QUARTER);
        if (rise[1]) coin_sum = coin_sum + (BAL_W+1)'(COIN_DIME);
        if (rise[0]) coin_sum = coin_sum + (BAL_W+1)'(COIN_NICKEL);
    end

    // The extra top bit flags a total that would not fit in the balance.
    assign coin_total = {1'b0, balance} + coin_sum;

    always_comb begin
        cost       = '0;
        cost_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (cur_index == 4'(i)) begin
                cost       = store_cost[8*i +: 8];
                cost_valid = 1'b1;
            end
        end
    end

    assign cost_ext   = BAL_W'(cost);
    assign funds_ok   = payment_method ? (cred_balance >= cost_ext) : (balance >= cost_ext);
    assign start_ok   = cost_valid && full_inventory && (cost != '0) && funds_ok;
    assign cancel_req = cancelled || (state == CANCEL);

    always_comb begin
        fsm_next        = fsm;
        balance_next    = balance;
        change_next     = change;
        new_credit_next = new_credit;
        reduce_next     = reduce_inventory;
        cstate_next     = change_state;
        cdone_next      = cancelled_done;

        if (change_state && change_state_done) cstate_next = 1'b0;
        if (cancelled_done && !cancelled && (state != CANCEL)) cdone_next = 1'b0;
        if (fsm == IDLE) change_next = '0;

        if (state == SELECT) begin
            fsm_next = IDLE;
        end else begin
            case (fsm)
                IDLE: begin
                    if (state == PAY) fsm_next = COLLECT;
                end
                COLLECT: begin
                    if (!payment_method && !coin_total[BAL_W])
                        balance_next = coin_total[BAL_W-1:0];
                    // Cancel takes priority over a purchase that could start this cycle.
                    if (cancel_req) begin
                        change_next  = balance;
                        balance_next = '0;
                        cdone_next   = 1'b1;
                        fsm_next     = REFUND;
                    end else if (start_ok) begin
                        reduce_next = 1'b1;
                        fsm_next    = REDUCE;
                    end
                end
                REDUCE: begin
                    if (reduce_inventory_done) begin
                        reduce_next = 1'b0;
                        cstate_next = 1'b1;
                        fsm_next    = FINISH;
                        if (payment_method) begin
                            new_credit_next = cred_balance - cost_ext;
                            change_next     = '0;
                        end else begin
                            change_next  = balance - cost_ext;
                            balance_next = '0;
                        end
                    end
                end
                FINISH, REFUND: begin
                end
                default: fsm_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            fsm              <= IDLE;
            coin_prev        <= '0;
            balance          <= '0;
            change           <= '0;
            new_credit       <= '0;
            reduce_inventory <= 1'b0;
            change_state     <= 1'b0;
            cancelled_done   <= 1'b0;
        end else begin
            fsm              <= fsm_next;
            coin_prev        <= coins;
            balance          <= balance_next;
            change           <= change_next;
            new_credit       <= new_credit_next;
            reduce_inventory <= reduce_next;
            change_state     <= cstate_next;
            cancelled_done   <= cdone_next;
        end
    end

    vend_payment_unit_change_dispenser #(
        .BAL_W(BAL_W)
    ) u_dispenser (
        .change    (change),
        .quarter_o (quarter_o),
        .dime_o    (dime_o),
        .nickel_o  (nickel_o)
    );

    vend_payment_unit_clock_gate_latch u_cg (
        .clk    (clk2),
        .clk_en (clk_en),
        .gclk   (gclk)
    );

endmodule

// File: tb/tb_vend_payment_unit.sv
// Self-checking bench for vend_payment_unit with directed scenarios and randomized coin/purchase runs.
`timescale 1ns/1ps
module tb_vend_payment_unit;
    import vend_payment_unit_pkg::*;

    logic        clk2 = 1'b0;
    logic        rst, clk_en, gclk;
    logic [1:0]  state;
    logic        cancelled, payment_method;
    logic [63:0] store_cost;
    logic [3:0]  cur_index;
    logic [8:0]  cred_balance;
    logic        dollar, quarter, dime, nickel;
    logic        full_inventory, reduce_inventory_done, change_state_done;
    logic        reduce_inventory, change_state, cancelled_done;
    logic [8:0]  balance, new_credit, change;
    logic [4:0]  quarter_o, dime_o, nickel_o;

    int n_vec = 0;
    int n_err = 0;
    time t_rise = 0;
    time last_width = 0;

    always #500 clk2 = ~clk2;
    always @(posedge gclk) t_rise = $time;
    always @(negedge gclk) last_width = $time - t_rise;

    vend_payment_unit dut (
        .clk2(clk2), .rst(rst), .clk_en(clk_en), .gclk(gclk), .state(state),
        .cancelled(cancelled), .payment_method(payment_method), .store_cost(store_cost),
        .cur_index(cur_index), .cred_balance(cred_balance), .dollar(dollar),
        .quarter(quarter), .dime(dime), .nickel(nickel), .full_inventory(full_inventory),
        .reduce_inventory_done(reduce_inventory_done), .change_state_done(change_state_done),
        .reduce_inventory(reduce_inventory), .change_state(change_state),
        .cancelled_done(cancelled_done), .balance(balance), .new_credit(new_credit),
        .change(change), .quarter_o(quarter_o), .dime_o(dime_o), .nickel_o(nickel_o)
    );

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; state = SELECT; cancelled = 1'b0; payment_method = 1'b0;
        store_cost = '0; cur_index = '0; cred_balance = '0;
        {dollar, quarter, dime, nickel} = 4'b0000;
        full_inventory = 1'b0; reduce_inventory_done = 1'b0; change_state_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] mask);
        {dollar, quarter, dime, nickel} = mask;
        tick();
        {dollar, quarter, dime, nickel} = 4'b0000;
        tick();
    endtask

    function automatic int coin_value(input logic [3:0] mask);
        return (mask[3] ? 100 : 0) + (mask[2] ? 25 : 0) + (mask[1] ? 10 : 0) + (mask[0] ? 5 : 0);
    endfunction

    task automatic greedy(input int amt, output int q, output int d, output int n);
        q = 0; d = 0; n = 0;
        while (amt >= 25) begin amt -= 25; q++; end
        while (amt >= 10) begin amt -= 10; d++; end
        while (amt >= 5)  begin amt -= 5;  n++; end
    endtask

    task automatic test_reset();
        apply_reset();
        state = PAY; tick();
        pulse(4'b1000);
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if (balance !== 9'd0) begin n_err++; $display("FAIL reset_balance got %0d want 0", balance); end
        n_vec++; if (change !== 9'd0) begin n_err++; $display("FAIL reset_change got %0d want 0", change); end
        n_vec++; if (new_credit !== 9'd0) begin n_err++; $display("FAIL reset_new_credit got %0d want 0", new_credit); end
        n_vec++; if ({reduce_inventory, change_state, cancelled_done} !== 3'b000) begin n_err++; $display("FAIL reset_handshakes got %b want 000", {reduce_inventory, change_state, cancelled_done}); end
        n_vec++; if ({quarter_o, dime_o, nickel_o} !== 15'd0) begin n_err++; $display("FAIL reset_coins got %0d/%0d/%0d want 0/0/0", quarter_o, dime_o, nickel_o); end
    endtask

    task automatic test_cash_vend();
        apply_reset();
        store_cost[23:16] = 8'd65; cur_index = 4'd2; full_inventory = 1'b1;
        state = PAY; tick();
        pulse(4'b0100); pulse(4'b0100); pulse(4'b0100);
        n_vec++; if (balance !== 9'd75) begin n_err++; $display("FAIL cash_balance got %0d want 75", balance); end
        n_vec++; if (reduce_inventory !== 1'b1) begin n_err++; $display("FAIL cash_reduce_start got %b want 1", reduce_inventory); end
        tick(); tick();
        n_vec++; if (reduce_inventory !== 1'b1) begin n_err++; $display("FAIL cash_reduce_hold got %b want 1", reduce_inventory); end
        reduce_inventory_done = 1'b1; tick(); reduce_inventory_done = 1'b0;
        n_vec++; if (reduce_inventory !== 1'b0) begin n_err++; $display("FAIL cash_reduce_drop got %b want 0", reduce_inventory); end
        n_vec++; if (change !== 9'd10) begin n_err++; $display("FAIL cash_change got %0d want 10", change); end
        n_vec++; if (balance !== 9'd0) begin n_err++; $display("FAIL cash_balance_clr got %0d want 0", balance); end
        n_vec++; if ({quarter_o, dime_o, nickel_o} !== {5'd0, 5'd1, 5'd0}) begin n_err++; $display("FAIL cash_coins got %0d/%0d/%0d want 0/1/0", quarter_o, dime_o, nickel_o); end
        tick(); tick();
        n_vec++; if (change_state !== 1'b1) begin n_err++; $display("FAIL cash_cstate_hold got %b want 1", change_state); end
        change_state_done = 1'b1; tick(); change_state_done = 1'b0;
        n_vec++; if (change_state !== 1'b0) begin n_err++; $display("FAIL cash_cstate_drop got %b want 0", change_state); end
        n_vec++; if (change !== 9'd10) begin n_err++; $display("FAIL cash_change_hold got %0d want 10", change); end
        state = SELECT; tick(); tick();
        n_vec++; if (change !== 9'd0) begin n_err++; $display("FAIL cash_change_idle got %0d want 0", change); end
    endtask

    task automatic test_cancel();
        apply_reset();
        state = PAY; tick();
        pulse(4'b1000); pulse(4'b0100); pulse(4'b0010);
        n_vec++; if (balance !== 9'd135) begin n_err++; $display("FAIL cancel_balance got %0d want 135", balance); end
        cancelled = 1'b1; tick();
        n_vec++; if (change !== 9'd135) begin n_err++; $display("FAIL cancel_change got %0d want 135", change); end
        n_vec++; if ({quarter_o, dime_o, nickel_o} !== {5'd5, 5'd1, 5'd0}) begin n_err++; $display("FAIL cancel_coins got %0d/%0d/%0d want 5/1/0", quarter_o, dime_o, nickel_o); end
        n_vec++; if (cancelled_done !== 1'b1) begin n_err++; $display("FAIL cancel_done got %b want 1", cancelled_done); end
        n_vec++; if (balance !== 9'd0) begin n_err++; $display("FAIL cancel_balance_clr got %0d want 0", balance); end
        cancelled = 1'b0; state = CANCEL; tick();
        n_vec++; if (cancelled_done !== 1'b1) begin n_err++; $display("FAIL cancel_done_hold got %b want 1", cancelled_done); end
        state = SELECT; tick(); tick();
        n_vec++; if (cancelled_done !== 1'b0) begin n_err++; $display("FAIL cancel_done_drop got %b want 0", cancelled_done); end
        n_vec++; if (change !== 9'd0) begin n_err++; $display("FAIL cancel_change_idle got %0d want 0", change); end
    endtask

    task automatic test_card();
        apply_reset();
        payment_method = 1'b1; cred_balance = 9'd300;
        store_cost[47:40] = 8'd120; cur_index = 4'd5; full_inventory = 1'b1;
        state = PAY; tick(); tick();
        n_vec++; if (reduce_inventory !== 1'b1) begin n_err++; $display("FAIL card_reduce got %b want 1", reduce_inventory); end
        reduce_inventory_done = 1'b1; tick(); reduce_inventory_done = 1'b0;
        n_vec++; if (new_credit !== 9'd180) begin n_err++; $display("FAIL card_new_credit got %0d want 180", new_credit); end
        n_vec++; if (change !== 9'd0) begin n_err++; $display("FAIL card_change got %0d want 0", change); end
        n_vec++; if ({reduce_inventory, change_state} !== 2'b01) begin n_err++; $display("FAIL card_handshake got %b want 01", {reduce_inventory, change_state}); end
        change_state_done = 1'b1; tick(); change_state_done = 1'b0;
        n_vec++; if (change_state !== 1'b0) begin n_err++; $display("FAIL card_cstate_drop got %b want 0", change_state); end
    endtask

    task automatic test_blocking();
        apply_reset();
        store_cost = {8{8'd50}}; cur_index = 4'd3;
        state = PAY; tick();
        pulse(4'b1000); pulse(4'b1000);
        tick(); tick(); tick();
        n_vec++; if (reduce_inventory !== 1'b0) begin n_err++; $display("FAIL block_no_stock got %b want 0", reduce_inventory); end
        n_vec++; if (balance !== 9'd200) begin n_err++; $display("FAIL block_balance got %0d want 200", balance); end
        cur_index = 4'd9; full_inventory = 1'b1;
        tick(); tick(); tick();
        n_vec++; if (reduce_inventory !== 1'b0) begin n_err++; $display("FAIL block_bad_index got %b want 0", reduce_inventory); end
        nickel = 1'b1;
        repeat (10) tick();
        nickel = 1'b0; tick();
        n_vec++; if (balance !== 9'd205) begin n_err++; $display("FAIL block_held_nickel got %0d want 205", balance); end
    endtask

    task automatic test_overflow();
        apply_reset();
        state = PAY; tick();
        repeat (5) pulse(4'b1000);
        n_vec++; if (balance !== 9'd500) begin n_err++; $display("FAIL ovf_balance500 got %0d want 500", balance); end
        pulse(4'b1000);
        n_vec++; if (balance !== 9'd500) begin n_err++; $display("FAIL ovf_dollar got %0d want 500", balance); end
        pulse(4'b0001);
        n_vec++; if (balance !== 9'd505) begin n_err++; $display("FAIL ovf_nickel got %0d want 505", balance); end
        pulse(4'b1111);
        pulse(4'b0010);
        n_vec++; if (balance !== 9'd505) begin n_err++; $display("FAIL ovf_ignored got %0d want 505", balance); end
        pulse(4'b0001);
        n_vec++; if (balance !== 9'd510) begin n_err++; $display("FAIL ovf_fit got %0d want 510", balance); end
    endtask

    task automatic test_cancel_priority();
        apply_reset();
        store_cost[7:0] = 8'd40; cur_index = 4'd0;
        state = PAY; tick();
        pulse(4'b1000);
        cancelled = 1'b1; full_inventory = 1'b1; tick(); cancelled = 1'b0;
        n_vec++; if ({reduce_inventory, cancelled_done} !== 2'b01) begin n_err++; $display("FAIL prio_cancel_wins got %b want 01", {reduce_inventory, cancelled_done}); end
        n_vec++; if (change !== 9'd100) begin n_err++; $display("FAIL prio_change got %0d want 100", change); end
        apply_reset();
        store_cost[7:0] = 8'd40; cur_index = 4'd0; full_inventory = 1'b1;
        state = PAY; tick();
        pulse(4'b1000);
        cancelled = 1'b1; tick();
        n_vec++; if ({reduce_inventory, cancelled_done} !== 2'b10) begin n_err++; $display("FAIL prio_reduce_commit got %b want 10", {reduce_inventory, cancelled_done}); end
        reduce_inventory_done = 1'b1; tick(); reduce_inventory_done = 1'b0; cancelled = 1'b0;
        n_vec++; if (change !== 9'd60 || cancelled_done !== 1'b0) begin n_err++; $display("FAIL prio_committed got change=%0d cdone=%b want 60/0", change, cancelled_done); end
        n_vec++; if ({quarter_o, dime_o, nickel_o} !== {5'd2, 5'd1, 5'd0}) begin n_err++; $display("FAIL prio_coins got %0d/%0d/%0d want 2/1/0", quarter_o, dime_o, nickel_o); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int m_bal, npulse, idx, cost, q, d, n;
            logic [3:0] mask;
            bit exp_start;
            apply_reset();
            store_cost = {$urandom, $urandom};
            state = PAY; tick();
            m_bal = 0;
            npulse = $urandom_range(1, 8);
            for (int p = 0; p < npulse; p++) begin
                mask = 4'($urandom_range(0, 15));
                {dollar, quarter, dime, nickel} = mask;
                repeat ($urandom_range(1, 3)) tick();
                {dollar, quarter, dime, nickel} = 4'b0000;
                tick();
                if (m_bal + coin_value(mask) <= 511) m_bal += coin_value(mask);
                n_vec++; if (balance !== 9'(m_bal)) begin n_err++; $display("FAIL rand_balance it=%0d got %0d want %0d", it, balance, m_bal); end
            end
            idx = $urandom_range(0, 7);
            cost = int'(store_cost[8*idx +: 8]);
            if ($urandom_range(0, 1) == 1) begin
                cur_index = 4'(idx); full_inventory = 1'b1; tick();
                exp_start = (cost != 0) && (m_bal >= cost);
                n_vec++; if (reduce_inventory !== exp_start) begin n_err++; $display("FAIL rand_start it=%0d got %b want %b", it, reduce_inventory, exp_start); end
                if (exp_start) begin
                    reduce_inventory_done = 1'b1; tick(); reduce_inventory_done = 1'b0;
                    m_bal = m_bal - cost;
                end else begin
                    cancelled = 1'b1; tick(); cancelled = 1'b0;
                end
            end else begin
                state = CANCEL; tick();
                n_vec++; if (cancelled_done !== 1'b1) begin n_err++; $display("FAIL rand_cdone it=%0d got %b want 1", it, cancelled_done); end
            end
            greedy(m_bal, q, d, n);
            n_vec++; if (change !== 9'(m_bal)) begin n_err++; $display("FAIL rand_change it=%0d got %0d want %0d", it, change, m_bal); end
            n_vec++; if ({quarter_o, dime_o, nickel_o} !== {5'(q), 5'(d), 5'(n)}) begin n_err++; $display("FAIL rand_coins it=%0d got %0d/%0d/%0d want %0d/%0d/%0d", it, quarter_o, dime_o, nickel_o, q, d, n); end
        end
    endtask

    task automatic test_clock_gate();
        @(negedge clk2); clk_en = 1'b0; #10;
        @(posedge clk2); #100;
        n_vec++; if (gclk !== 1'b0) begin n_err++; $display("FAIL cg_off got %b want 0", gclk); end
        clk_en = 1'b1; #100;
        n_vec++; if (gclk !== 1'b0) begin n_err++; $display("FAIL cg_no_late_rise got %b want 0", gclk); end
        @(posedge clk2); #1;
        n_vec++; if (gclk !== 1'b1) begin n_err++; $display("FAIL cg_on got %b want 1", gclk); end
        #100 clk_en = 1'b0; #100;
        n_vec++; if (gclk !== 1'b1) begin n_err++; $display("FAIL cg_no_early_fall got %b want 1", gclk); end
        @(negedge clk2); #1;
        n_vec++; if (last_width !== 500) begin n_err++; $display("FAIL cg_width got %0t want 500", last_width); end
        @(posedge clk2); #1;
        n_vec++; if (gclk !== 1'b0) begin n_err++; $display("FAIL cg_gated got %b want 0", gclk); end
        clk_en = 1'b1;
    endtask

    initial begin
        #30_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clk_en = 1'b1;
        test_reset();
        test_cash_vend();
        test_cancel();
        test_card();
        test_blocking();
        test_overflow();
        test_cancel_priority();
        test_random();
        test_clock_gate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
